// File: rtl/cpu_bus_bridge_pkg.sv
// rtl/cpu_bus_bridge_pkg.sv - shared types and constants for the CPU bus bridge
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    IO_WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    REG_MEM,
    REG_IO,
    REG_NONE
  } region_e;

  // Read data returned for unmapped or timed-out accesses (truncated to DATA_W).
  localparam logic [63:0] RD_ALL_ONES = '1;

endpackage

// File: rtl/cpu_bus_bridge_if.sv
// rtl/cpu_bus_bridge_if.sv - CPU-side and target-side bus signals of the bridge
interface cpu_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_cpu_bus_clk;
  logic              i_cpu_bus_we;
  logic [ADDR_W-1:0] i_cpu_bus_addr;
  logic [DATA_W-1:0] i_cpu_bus_data;
  logic [DATA_W-1:0] o_cpu_bus_data;
  logic              o_cpu_data_ready;
  logic              o_bus_err;
  logic              o_mem_req;
  logic              o_io_req;
  logic              o_mem_we;
  logic              o_io_we;
  logic [ADDR_W-1:0] o_tgt_addr;
  logic [DATA_W-1:0] o_tgt_data;
  logic              i_mem_ack;
  logic              i_io_ack;
  logic [DATA_W-1:0] i_mem_data;
  logic [DATA_W-1:0] i_io_data;

  // Bridge side.
  modport slave (
    input  i_cpu_bus_clk, i_cpu_bus_we, i_cpu_bus_addr, i_cpu_bus_data,
    input  i_mem_ack, i_io_ack, i_mem_data, i_io_data,
    output o_cpu_bus_data, o_cpu_data_ready, o_bus_err,
    output o_mem_req, o_io_req, o_mem_we, o_io_we, o_tgt_addr, o_tgt_data
  );

  // CPU and target fabric side.
  modport master (
    output i_cpu_bus_clk, i_cpu_bus_we, i_cpu_bus_addr, i_cpu_bus_data,
    output i_mem_ack, i_io_ack, i_mem_data, i_io_data,
    input  o_cpu_bus_data, o_cpu_data_ready, o_bus_err,
    input  o_mem_req, o_io_req, o_mem_we, o_io_we, o_tgt_addr, o_tgt_data
  );

endinterface

// File: rtl/cpu_bus_bridge_timeout.sv
// rtl/cpu_bus_bridge_timeout.sv - wait-state limit counter, built only with BUS_TIMEOUT_EN
`ifdef BUS_TIMEOUT_EN
module bus_timeout_counter #(
  parameter int LIMIT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts completed wait cycles; expiry is flagged during the LIMIT-th one.
  assign o_expired = i_enable && (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && !o_expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/cpu_bus_bridge.sv
// rtl/cpu_bus_bridge.sv - CPU bus to memory/IO target bridge with wait states
// Optional target wait limit enabled by defining BUS_TIMEOUT_EN.
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter logic [ADDR_W-1:0] IO_BASE      = ADDR_W'(32'h0000_FE00),
  parameter logic [ADDR_W-1:0] IO_MASK      = ADDR_W'(32'hFFFF_FF00),
  parameter logic [ADDR_W-1:0] MEM_TOP      = ADDR_W'(32'h0000_FFFF),
  parameter int              TIMEOUT_CYCLES = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  cpu_bus_bridge_if.slave  bus
);

  state_e            state_q, state_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              mem_req_q, mem_req_d;
  logic              io_req_q, io_req_d;
  logic              mem_we_q, mem_we_d;
  logic              io_we_q, io_we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              err_flag_q, err_flag_d;

  region_e region;
  logic    req_edge;
  logic    in_wait;
  logic    expired;

  assign req_edge = bus.i_cpu_bus_clk & ~strobe_q;
  assign in_wait  = (state_q == MEM_WAIT) || (state_q == IO_WAIT);

`ifdef BUS_TIMEOUT_EN
  bus_timeout_counter #(
    .LIMIT     (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (!in_wait),
    .i_enable  (in_wait),
    .o_expired (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign expired        = 1'b0;
`endif

  // I/O window takes priority over the memory range.
  always_comb begin
    region = REG_NONE;
    if ((bus.i_cpu_bus_addr & IO_MASK) == IO_BASE) begin
      region = REG_IO;
    end else if (bus.i_cpu_bus_addr <= MEM_TOP) begin
      region = REG_MEM;
    end
  end

  always_comb begin
    state_d    = state_q;
    strobe_d   = bus.i_cpu_bus_clk;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    mem_req_d  = mem_req_q;
    io_req_d   = io_req_q;
    mem_we_d   = mem_we_q;
    io_we_d    = io_we_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    err_flag_d = err_flag_q;

    case (state_q)
      IDLE: begin
        if (req_edge) begin
          addr_d     = bus.i_cpu_bus_addr;
          wdata_d    = bus.i_cpu_bus_data;
          we_d       = bus.i_cpu_bus_we;
          err_flag_d = 1'b0;
          case (region)
            REG_IO: begin
              state_d  = IO_WAIT;
              io_req_d = 1'b1;
              io_we_d  = bus.i_cpu_bus_we;
            end
            REG_MEM: begin
              state_d   = MEM_WAIT;
              mem_req_d = 1'b1;
              mem_we_d  = bus.i_cpu_bus_we;
            end
            default: begin
              state_d    = RESP;
              rdata_d    = DATA_W'(RD_ALL_ONES);
              err_flag_d = 1'b1;
            end
          endcase
        end
      end

      MEM_WAIT: begin
        // An ack on the expiry cycle still wins over the timeout.
        if (mem_req_q && bus.i_mem_ack) begin
          rdata_d   = we_q ? '0 : bus.i_mem_data;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
        end else if (expired) begin
          rdata_d    = DATA_W'(RD_ALL_ONES);
          err_flag_d = 1'b1;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = RESP;
        end
      end

      IO_WAIT: begin
        if (io_req_q && bus.i_io_ack) begin
          rdata_d  = we_q ? '0 : bus.i_io_data;
          io_req_d = 1'b0;
          io_we_d  = 1'b0;
          state_d  = RESP;
        end else if (expired) begin
          rdata_d    = DATA_W'(RD_ALL_ONES);
          err_flag_d = 1'b1;
          io_req_d   = 1'b0;
          io_we_d    = 1'b0;
          state_d    = RESP;
        end
      end

      RESP: begin
        ready_d    = 1'b1;
        err_d      = err_flag_q;
        err_flag_d = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      strobe_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      mem_req_q  <= 1'b0;
      io_req_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      io_we_q    <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      strobe_q   <= strobe_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      mem_req_q  <= mem_req_d;
      io_req_q   <= io_req_d;
      mem_we_q   <= mem_we_d;
      io_we_q    <= io_we_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign bus.o_cpu_bus_data   = rdata_q;
  assign bus.o_cpu_data_ready = ready_q;
  assign bus.o_bus_err        = err_q;
  assign bus.o_mem_req        = mem_req_q;
  assign bus.o_io_req         = io_req_q;
  assign bus.o_mem_we         = mem_we_q;
  assign bus.o_io_we          = io_we_q;
  assign bus.o_tgt_addr       = addr_q;
  assign bus.o_tgt_data       = wdata_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// tb/tb_cpu_bus_bridge.sv - self-checking bench for cpu_bus_bridge
module tb_cpu_bus_bridge;

  localparam int T = 4;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpu_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cpu_bus_bridge #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 0 = memory, 1 = I/O, 2 = unmapped
  function automatic int ref_region(input logic [31:0] a);
    if ((a & 32'hFFFF_FF00) == 32'h0000_FE00) return 1;
    if (a <= 32'h0000_FFFF) return 0;
    return 2;
  endfunction

  // Called at a negedge; raises the strobe, accepted at the next posedge.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int d, input logic [31:0] ack_data, input int drop_at,
                         input bit keep_high);
    int          region;
    bit          timed_out;
    int          eff_d;
    bit          exp_err;
    logic [31:0] exp_data;
    int          n;
    int          seen;
    bit          req_on;
    region    = ref_region(addr);
    timed_out = TO_EN && (region != 2) && (d > T - 1);
    eff_d     = timed_out ? T - 1 : d;
    exp_err   = (region == 2) || timed_out;
    exp_data  = exp_err ? 32'hFFFF_FFFF : (we ? 32'h0 : ack_data);
    n         = (region == 2) ? 5 : eff_d + 4;
    seen      = 0;
    bus.i_cpu_bus_we   = we;
    bus.i_cpu_bus_addr = addr;
    bus.i_cpu_bus_data = wdata;
    bus.i_cpu_bus_clk  = 1'b1;
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (region == 2) begin
        chk1("unm_mem_req", bus.o_mem_req, 1'b0);
        chk1("unm_io_req", bus.o_io_req, 1'b0);
        if (bus.o_cpu_data_ready === 1'b1) begin
          seen++;
          chk1("unm_err", bus.o_bus_err, 1'b1);
          chk32("unm_rdata", bus.o_cpu_bus_data, 32'hFFFF_FFFF);
        end else begin
          chk1("unm_err_idle", bus.o_bus_err, 1'b0);
        end
      end else begin
        req_on = (k <= eff_d);
        chk1("mem_req", bus.o_mem_req, region == 0 && req_on);
        chk1("io_req", bus.o_io_req, region == 1 && req_on);
        chk1("mem_we", bus.o_mem_we, region == 0 && req_on && we);
        chk1("io_we", bus.o_io_we, region == 1 && req_on && we);
        if (req_on) begin
          chk32("tgt_addr", bus.o_tgt_addr, addr);
          chk32("tgt_data", bus.o_tgt_data, wdata);
        end
        chk1("ready", bus.o_cpu_data_ready, k == eff_d + 2);
        chk1("err", bus.o_bus_err, exp_err && (k == eff_d + 2));
        if (k == eff_d + 2) chk32("rdata", bus.o_cpu_bus_data, exp_data);
      end
      // Active target acks on cycle d; the other target chatters harmlessly.
      bus.i_mem_ack  = (region == 0) ? (k == d) : 1'($urandom_range(0, 1));
      bus.i_io_ack   = (region == 1) ? (k == d) : 1'($urandom_range(0, 1));
      bus.i_mem_data = (region == 0 && k == d) ? ack_data : $urandom();
      bus.i_io_data  = (region == 1 && k == d) ? ack_data : $urandom();
      if (!keep_high) begin
        if (k == drop_at) bus.i_cpu_bus_clk = 1'b0;
        if (k == drop_at + 1 && k < eff_d) bus.i_cpu_bus_clk = 1'b1;
        if (region == 2 || k >= eff_d + 1) bus.i_cpu_bus_clk = 1'b0;
      end
    end
    if (region == 2) chk32("unm_ready_count", seen, 32'd1);
    bus.i_mem_ack = 1'b0;
    bus.i_io_ack  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    rst = 1'b1;
    bus.i_cpu_bus_clk  = 1'b1;
    bus.i_cpu_bus_we   = 1'b0;
    bus.i_cpu_bus_addr = 32'h0000_1234;
    bus.i_cpu_bus_data = 32'h0;
    bus.i_mem_ack      = 1'b0;
    bus.i_io_ack       = 1'b0;
    bus.i_mem_data     = 32'h0;
    bus.i_io_data      = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_mem_req", bus.o_mem_req, 1'b0);
    chk1("rst_io_req", bus.o_io_req, 1'b0);
    chk1("rst_ready", bus.o_cpu_data_ready, 1'b0);
    chk1("rst_err", bus.o_bus_err, 1'b0);
    chk32("rst_rdata", bus.o_cpu_bus_data, 32'h0);
    chk32("rst_tgt_addr", bus.o_tgt_addr, 32'h0);
    chk32("rst_tgt_data", bus.o_tgt_data, 32'h0);
    rst = 1'b0;

    // Strobe held through reset release, mem read with three request cycles.
    run_txn(1'b0, 32'h0000_1234, 32'h0, 2, 32'hDEAD_BEEF, -1, 1'b0);
    // Zero-wait I/O write.
    run_txn(1'b1, 32'h0000_FE10, 32'h0000_0055, 0, 32'h1234_5678, -1, 1'b0);
    // Unmapped read.
    run_txn(1'b0, 32'h0002_0000, 32'h0, 0, 32'h0, -1, 1'b0);
    // Long wait: unbounded without the timeout, error response with it.
    run_txn(1'b0, 32'h0000_4000, 32'h0, 10, 32'hCAFE_F00D, 1, 1'b0);
    run_txn(1'b0, 32'h0000_FE80, 32'h0, 10, 32'hCAFE_F00D, -1, 1'b0);
    // Ack on the last permitted wait cycle.
    run_txn(1'b0, 32'h0000_0100, 32'h0, T - 1, 32'h0BAD_CAFE, -1, 1'b0);

    // Reset during MEM_WAIT, strobe kept high through release.
    bus.i_cpu_bus_we   = 1'b0;
    bus.i_cpu_bus_addr = 32'h0000_1000;
    bus.i_cpu_bus_clk  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("pre_rst_mem_req", bus.o_mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("async_rst_req", bus.o_mem_req, 1'b0);
    chk1("async_rst_ready", bus.o_cpu_data_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk1("in_rst_ready", bus.o_cpu_data_ready, 1'b0);
    rst = 1'b0;
    run_txn(1'b0, 32'h0000_1000, 32'h0, 1, 32'h1111_2222, -1, 1'b0);

    // Strobe stays high after the response: no second transaction.
    run_txn(1'b0, 32'h0000_2000, 32'h0, 0, 32'h3333_4444, -1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("hold_mem_req", bus.o_mem_req, 1'b0);
      chk1("hold_ready", bus.o_cpu_data_ready, 1'b0);
    end
    bus.i_cpu_bus_clk = 1'b0;

    // Acks with no request outstanding are ignored.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("idle_mem_req", bus.o_mem_req, 1'b0);
      chk1("idle_io_req", bus.o_io_req, 1'b0);
      chk1("idle_ready", bus.o_cpu_data_ready, 1'b0);
      bus.i_mem_ack  = 1'b1;
      bus.i_io_ack   = 1'b1;
      bus.i_mem_data = $urandom();
      bus.i_io_data  = $urandom();
    end
    bus.i_mem_ack = 1'b0;
    bus.i_io_ack  = 1'b0;
    @(negedge clk);
    chk1("idle_ready_end", bus.o_cpu_data_ready, 1'b0);

    // Decode boundaries.
    run_txn(1'b0, 32'h0000_FFFF, 32'h0, 1, 32'hA5A5_0001, -1, 1'b0);
    run_txn(1'b0, 32'h0001_0000, 32'h0, 0, 32'h0, -1, 1'b0);
    run_txn(1'b1, 32'h0000_FEFF, 32'h7777_0000, 1, 32'h0, -1, 1'b0);
    run_txn(1'b0, 32'h0000_FDFF, 32'h0, 0, 32'hA5A5_0002, -1, 1'b0);
    run_txn(1'b0, 32'hFFFF_FE00, 32'h0, 0, 32'h0, -1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0)      a = 32'($urandom_range(0, 32'h0000_FDFF));
      else if (kind == 1) a = 32'h0000_FE00 | 32'($urandom_range(0, 255));
      else                a = 32'h0001_0000 + 32'($urandom_range(0, 32'h00FF_FFFF));
      run_txn(1'($urandom_range(0, 1)), a, $urandom(), $urandom_range(0, 6), $urandom(),
              $urandom_range(0, 6), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
